// File: rtl/cover_seq_pkg.sv
// rtl/cover_seq_pkg.sv - shared state encoding, default sizing and width helper for the cover sequencer
package cover_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUIET = 2'd1,
        ST_STIM  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_IDLE_CYC = 10;
    localparam int DEF_HIT_CYC  = 2;
    localparam int DEF_CNT_W    = 8;

    // Bits needed to hold 0..n, never less than one.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cover_seq_mon.sv
// rtl/cover_seq_mon.sv - cover-hit and assertion-failure counters; COVER_SEQ_ASSERT_EN enables the assertion side
module cover_seq_mon
    import cover_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    output logic [CNT_W-1:0] cov_hits,
    output logic [CNT_W-1:0] asr_fails,
    output logic             fail
);

    localparam logic [CNT_W-1:0] SAT = '1;

    // Count every cycle the cover condition is presented, holding at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cov_hits <= '0;
        end else if (a && (cov_hits != SAT)) begin
            cov_hits <= cov_hits + CNT_W'(1);
        end
    end

`ifdef COVER_SEQ_ASSERT_EN
    // Under the cover condition, b must be high; count and latch each violation.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            asr_fails <= '0;
            fail      <= 1'b0;
        end else if (a) begin
            assert (b) else $warning("cover_seq_mon: b low while a high");
            if (!b) begin
                fail <= 1'b1;
                if (asr_fails != SAT) begin
                    asr_fails <= asr_fails + CNT_W'(1);
                end
            end
        end
    end
`else
    logic unused_b;
    assign unused_b  = b;
    assign asr_fails = '0;
    assign fail      = 1'b0;
`endif

endmodule

// File: rtl/cover_seq_ctrl.sv
// rtl/cover_seq_ctrl.sv - quiet/stimulus sequencer driving a/b into the monitor; COVER_SEQ_ASSERT_EN selects assertion counting
module cover_seq_ctrl
    import cover_seq_pkg::*;
#(
    parameter int IDLE_CYC = DEF_IDLE_CYC,
    parameter int HIT_CYC  = DEF_HIT_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inj_fail,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cov_hits,
    output logic [CNT_W-1:0] asr_fails,
    output logic             fail
);

    localparam int QW = cnt_width(IDLE_CYC);
    localparam int KW = cnt_width(HIT_CYC);
    localparam logic [QW-1:0] Q_LAST = QW'(IDLE_CYC - 1);
    localparam logic [KW-1:0] K_LAST = KW'(HIT_CYC - 1);

    state_t        state;
    logic [QW-1:0] qcnt;
    logic [KW-1:0] kidx;
    logic          accept;

    // A start is only honoured from IDLE; the monitor clears on the same edge.
    assign accept = (state == ST_IDLE) && start;

    // Sequencer with registered stimulus: each edge loads the a/b shown in the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            qcnt  <= '0;
            kidx  <= '0;
            a     <= 1'b0;
            b     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        qcnt <= '0;
                        kidx <= '0;
                        if (IDLE_CYC == 0) begin
                            state <= ST_STIM;
                            a     <= 1'b1;
                            b     <= ~inj_fail;
                        end else begin
                            state <= ST_QUIET;
                        end
                    end
                end
                ST_QUIET: begin
                    if (qcnt == Q_LAST) begin
                        state <= ST_STIM;
                        kidx  <= '0;
                        a     <= 1'b1;
                        b     <= ~inj_fail;
                    end else begin
                        qcnt <= qcnt + QW'(1);
                    end
                end
                ST_STIM: begin
                    if (kidx == K_LAST) begin
                        state <= ST_DONE;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // Next index k+1 is even exactly when the current index is odd.
                        kidx <= kidx + KW'(1);
                        a    <= kidx[0];
                        b    <= ~inj_fail;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    a     <= 1'b0;
                    b     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    cover_seq_mon #(
        .CNT_W(CNT_W)
    ) u_mon (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .a        (a),
        .b        (b),
        .cov_hits (cov_hits),
        .asr_fails(asr_fails),
        .fail     (fail)
    );

endmodule

// File: tb/tb_cover_seq_ctrl.sv
// tb/tb_cover_seq_ctrl.sv - scoreboard bench for cover_seq_ctrl (default and saturating configurations)
module tb_cover_seq_ctrl;

    localparam int D_IDLE = 10;
    localparam int D_HIT  = 2;
    localparam int D_CW   = 8;
`ifdef COVER_SEQ_ASSERT_EN
    localparam bit ASR_EN = 1'b1;
`else
    localparam bit ASR_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] sig;    // {a, b, busy, done}
        int         hits;
        int         fails;
        logic       fl;
        bit         last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    logic inj_fail = 1'b0;
    logic sel = 1'b0;

    logic       a1, b1, busy1, done1, fail1;
    logic [7:0] hits1, fails1;
    logic       a2, b2, busy2, done2, fail2;
    logic [1:0] hits2, fails2;

    always #5 clk = ~clk;

    cover_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start1), .inj_fail(inj_fail),
        .a(a1), .b(b1), .busy(busy1), .done(done1),
        .cov_hits(hits1), .asr_fails(fails1), .fail(fail1)
    );

    cover_seq_ctrl #(.IDLE_CYC(0), .HIT_CYC(9), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .inj_fail(inj_fail),
        .a(a2), .b(b2), .busy(busy2), .done(done2),
        .cov_hits(hits2), .asr_fails(fails2), .fail(fail2)
    );

    function automatic logic [3:0] obs_sig();
        return sel ? {a2, b2, busy2, done2} : {a1, b1, busy1, done1};
    endfunction
    function automatic int obs_hits();
        return sel ? int'(hits2) : int'(hits1);
    endfunction
    function automatic int obs_fails();
        return sel ? int'(fails2) : int'(fails1);
    endfunction
    function automatic logic obs_fail();
        return sel ? fail2 : fail1;
    endfunction

    // Reference model: per-cycle expectations for one sequence started at edge 0.
    task automatic push_trace(input int quiet, input int hit, input int cw, input bit inj);
        int   sat;
        int   h;
        int   f;
        exp_t e;
        sat = (1 << cw) - 1;
        h = 0;
        f = 0;
        for (int i = 0; i < quiet; i++) begin
            e = '{sig: 4'b0010, hits: 0, fails: 0, fl: 1'b0, last: 1'b0};
            exp_q.push_back(e);
        end
        for (int k = 0; k < hit; k++) begin
            e = '{sig: {(k % 2 == 0), ~inj, 1'b1, 1'b0}, hits: 0, fails: 0, fl: 1'b0, last: 1'b0};
            exp_q.push_back(e);
            if (k % 2 == 0) begin
                h++;
                if (inj) f++;
            end
        end
        if (!ASR_EN) f = 0;
        e = '{sig: 4'b0011, hits: (h > sat) ? sat : h, fails: (f > sat) ? sat : f,
              fl: (f > 0), last: 1'b1};
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({a1, b1, busy1, done1, hits1, fails1, fail1} !== 21'd0) begin
            n_mis++;
            $display("FAIL reset_main: got %b required all zero", {a1, b1, busy1, done1, hits1, fails1, fail1});
        end
        n_cmp++;
        if ({a2, b2, busy2, done2, hits2, fails2, fail2} !== 9'd0) begin
            n_mis++;
            $display("FAIL reset_sat: got %b required all zero", {a2, b2, busy2, done2, hits2, fails2, fail2});
        end
        rst = 1'b0;
    endtask

    // Full sequence on the selected instance, checked every cycle through DONE and one IDLE cycle.
    task automatic test_run(input string name, input bit s, input bit inj);
        exp_t       e;
        logic [3:0] o;
        int         c;
        int         a_high;
        sel = s;
        inj_fail = inj;
        if (s) push_trace(0, 9, 2, inj);
        else   push_trace(D_IDLE, D_HIT, D_CW, inj);
        if (s) start2 = 1'b1;
        else   start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        c = 1;
        a_high = 0;
        n_cmp++;
        if (obs_hits() !== 0 || obs_fails() !== 0 || obs_fail() !== 1'b0) begin
            n_mis++;
            $display("FAIL %s_clear: got hits=%0d fails=%0d fail=%b required 0/0/0", name, obs_hits(), obs_fails(), obs_fail());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_sig();
            if (o[3]) a_high++;
            n_cmp++;
            if (o !== e.sig) begin
                n_mis++;
                $display("FAIL %s_cyc%0d: {a,b,busy,done} got %b required %b", name, c, o, e.sig);
            end
            if (e.last) begin
                n_cmp++;
                if (obs_hits() !== e.hits || obs_fails() !== e.fails || obs_fail() !== e.fl) begin
                    n_mis++;
                    $display("FAIL %s_counts: got hits=%0d fails=%0d fail=%b required %0d/%0d/%b",
                             name, obs_hits(), obs_fails(), obs_fail(), e.hits, e.fails, e.fl);
                end
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        @(posedge clk); #1;
        o = obs_sig();
        n_cmp++;
        if (o !== 4'b0000 || obs_hits() !== e.hits || obs_fails() !== e.fails || obs_fail() !== e.fl) begin
            n_mis++;
            $display("FAIL %s_idle_hold: got sig=%b hits=%0d fails=%0d fail=%b required 0000/%0d/%0d/%b",
                     name, o, obs_hits(), obs_fails(), obs_fail(), e.hits, e.fails, e.fl);
        end
        if (s) begin
            n_cmp++;
            if (a_high != 5 || c != 10) begin
                n_mis++;
                $display("FAIL %s_shape: got a_high=%0d done_cycle=%0d required 5/10", name, a_high, c);
            end
        end
        sel = 1'b0;
        inj_fail = 1'b0;
    endtask

    task automatic test_mid_reset();
        exp_t       e;
        logic [3:0] o;
        sel = 1'b0;
        inj_fail = 1'b0;
        push_trace(D_IDLE, D_HIT, D_CW, 1'b0);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            e = exp_q.pop_front();
            o = obs_sig();
            n_cmp++;
            if (o !== e.sig) begin
                n_mis++;
                $display("FAIL mid_reset_cyc%0d: {a,b,busy,done} got %b required %b", c, o, e.sig);
            end
            if (c < 11) begin
                @(posedge clk); #1;
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({a1, b1, busy1, done1, hits1, fails1, fail1} !== 21'd0) begin
            n_mis++;
            $display("FAIL mid_reset_cyc12: got %b required all zero", {a1, b1, busy1, done1, hits1, fails1, fail1});
        end
        exp_q.delete();
    endtask

    task automatic test_start_ignored();
        exp_t       e;
        logic [3:0] o;
        int         c;
        int         dones;
        sel = 1'b0;
        inj_fail = 1'b0;
        push_trace(D_IDLE, D_HIT, D_CW, 1'b0);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        c = 1;
        dones = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_sig();
            if (o[0]) dones++;
            n_cmp++;
            if (o !== e.sig) begin
                n_mis++;
                $display("FAIL ignore_cyc%0d: {a,b,busy,done} got %b required %b", c, o, e.sig);
            end
            start1 = (c == 5 || c == 13);
            if (exp_q.size() > 0) begin
                @(posedge clk); #1;
                c++;
            end
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        o = obs_sig();
        n_cmp++;
        if (o !== 4'b0000 || hits1 !== 8'd1 || dones != 1) begin
            n_mis++;
            $display("FAIL ignore_cyc14: got sig=%b hits=%0d dones=%0d required 0000/1/1", o, hits1, dones);
        end
        push_trace(D_IDLE, D_HIT, D_CW, 1'b0);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n_cmp++;
        if (busy1 !== 1'b1 || hits1 !== 8'd0 || fails1 !== 8'd0 || fail1 !== 1'b0) begin
            n_mis++;
            $display("FAIL restart_clear: got busy=%b hits=%0d fails=%0d fail=%b required 1/0/0/0", busy1, hits1, fails1, fail1);
        end
        c = 15;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_sig();
            n_cmp++;
            if (o !== e.sig) begin
                n_mis++;
                $display("FAIL restart_cyc%0d: {a,b,busy,done} got %b required %b", c, o, e.sig);
            end
            if (e.last) begin
                n_cmp++;
                if (obs_hits() !== e.hits || obs_fails() !== e.fails || obs_fail() !== e.fl) begin
                    n_mis++;
                    $display("FAIL restart_counts: got hits=%0d fails=%0d fail=%b required %0d/%0d/%b",
                             obs_hits(), obs_fails(), obs_fail(), e.hits, e.fails, e.fl);
                end
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_run("nominal", 1'b0, 1'b0);
        test_run("inj_fail", 1'b0, 1'b1);
        test_run("back_to_back", 1'b0, 1'b0);
        test_mid_reset();
        test_run("after_reset", 1'b0, 1'b0);
        test_start_ignored();
        test_run("saturate", 1'b1, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
